// File: rtl/itrx_aib_phy_bsr_seg.sv
// AIB JTAG boundary-scan segment: NCH capture/shift cells, parallel update stage, EXTEST output mux.
// Define ITRX_AIB_PHY_BSR_PARITY_EN to add an even-parity cell at the si end of the chain.
module itrx_aib_phy_bsr_seg #(
  parameter int NCH     = 8,
  parameter bit UPD_RST = 1'b0,
  parameter int CW      = $clog2(NCH + 2)
) (
  input  logic           jtag_clkdr,
  input  logic           jtag_rstb,
  input  logic           jtag_scan_en,
  input  logic           jtag_cap_en,
  input  logic           jtag_update,
  input  logic           jtag_mode,
  input  logic [NCH-1:0] d_i,
  input  logic [NCH-1:0] func_i,
  input  logic           si,
  output logic [NCH-1:0] q_o,
  output logic           so,
  output logic [CW-1:0]  shift_cnt_o,
  output logic           shift_done_o,
  output logic           par_err_o
);

`ifdef ITRX_AIB_PHY_BSR_PARITY_EN
  localparam int L = NCH + 1;
`else
  localparam int L = NCH;
`endif

  logic [L-1:0]   sr_reg, sr_next, sr_shift, sr_cap;
  logic [NCH-1:0] upd_reg, upd_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  // si enters at the top cell; sr[0] is the cell nearest so
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_shift
      if (gi == L - 1) begin : g_head
        assign sr_shift[gi] = si;
      end else begin : g_body
        assign sr_shift[gi] = sr_reg[gi+1];
      end
    end
  endgenerate

`ifdef ITRX_AIB_PHY_BSR_PARITY_EN
  assign sr_cap = {^d_i, d_i};
`else
  assign sr_cap = d_i;
`endif

  always_comb begin
    sr_next  = sr_reg;
    cnt_next = cnt_reg;
    upd_next = upd_reg;
    if (jtag_scan_en) begin
      sr_next = sr_shift;
      if (cnt_reg != CW'(L)) cnt_next = cnt_reg + CW'(1);
    end else begin
      if (jtag_cap_en) begin
        sr_next  = sr_cap;
        cnt_next = '0;
      end
      // Update always sees the pre-edge chain, even when capturing in the same cycle
      if (jtag_update) upd_next = sr_reg[NCH-1:0];
    end
  end

  always_ff @(posedge jtag_clkdr or negedge jtag_rstb) begin
    if (!jtag_rstb) begin
      sr_reg  <= '0;
      upd_reg <= {NCH{UPD_RST}};
      cnt_reg <= '0;
    end else begin
      sr_reg  <= sr_next;
      upd_reg <= upd_next;
      cnt_reg <= cnt_next;
    end
  end

`ifdef ITRX_AIB_PHY_BSR_PARITY_EN
  logic par_err_reg, par_err_next;

  always_comb begin
    par_err_next = par_err_reg;
    if (!jtag_scan_en && jtag_update) par_err_next = (^sr_reg[NCH-1:0]) ^ sr_reg[NCH];
  end

  always_ff @(posedge jtag_clkdr or negedge jtag_rstb) begin
    if (!jtag_rstb) par_err_reg <= 1'b0;
    else            par_err_reg <= par_err_next;
  end

  assign par_err_o = par_err_reg;
`else
  assign par_err_o = 1'b0;
`endif

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_qmux
      assign q_o[gi] = jtag_mode ? upd_reg[gi] : func_i[gi];
    end
  endgenerate

  assign so           = sr_reg[0];
  assign shift_cnt_o  = cnt_reg;
  assign shift_done_o = (cnt_reg == CW'(L));

endmodule

// File: tb/tb_itrx_aib_phy_bsr_seg.sv
// Directed self-checking bench for itrx_aib_phy_bsr_seg (NCH=8, UPD_RST=1).
module tb_itrx_aib_phy_bsr_seg;
  localparam int NCH = 8;
  localparam int CW  = $clog2(NCH + 2);
`ifdef ITRX_AIB_PHY_BSR_PARITY_EN
  localparam int L = NCH + 1;
`else
  localparam int L = NCH;
`endif

  logic           clk = 1'b0;
  logic           rstb, scan_en, cap_en, update, mode, si;
  logic [NCH-1:0] d_i, func_i, q_o;
  logic           so, shift_done, par_err;
  logic [CW-1:0]  shift_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  itrx_aib_phy_bsr_seg #(.NCH(NCH), .UPD_RST(1'b1)) dut (
    .jtag_clkdr   (clk),
    .jtag_rstb    (rstb),
    .jtag_scan_en (scan_en),
    .jtag_cap_en  (cap_en),
    .jtag_update  (update),
    .jtag_mode    (mode),
    .d_i          (d_i),
    .func_i       (func_i),
    .si           (si),
    .q_o          (q_o),
    .so           (so),
    .shift_cnt_o  (shift_cnt),
    .shift_done_o (shift_done),
    .par_err_o    (par_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic sc, input logic cp, input logic up, input logic s);
    scan_en = sc; cap_en = cp; update = up; si = s;
    @(posedge clk); #1;
    $display("cyc scan=%0b cap=%0b upd=%0b si=%0b -> so=%0b cnt=%0d done=%0b q=%h perr=%0b",
             sc, cp, up, s, so, shift_cnt, shift_done, q_o, par_err);
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 0; i < L; i++) cyc(1'b1, 1'b0, 1'b0, w[i]);
  endtask

  logic [15:0] cw16;

  initial begin
    rstb = 1'b0; scan_en = 1'b0; cap_en = 1'b0; update = 1'b0; mode = 1'b1;
    si = 1'b0; d_i = '0; func_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_so", so, 0);
    chk("rst_cnt", shift_cnt, 0);
    chk("rst_done", shift_done, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_q", q_o, 8'hFF);
    rstb = 1'b1;

    // Reset asserted mid-shift
    d_i = 8'hA5;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("cap_so", so, 1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_so", so, 1);
    chk("pre_rst_cnt", shift_cnt, 2);
    rstb = 1'b0;
    #1;
    chk("mid_rst_so", so, 0);
    chk("mid_rst_cnt", shift_cnt, 0);
    chk("mid_rst_q", q_o, 8'hFF);
    @(posedge clk); #1;
    rstb = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_sr_clear", so, 0);

    // Capture then shift past the chain length
    cw16 = 16'h00A5;
    d_i  = 8'hA5;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("cs_so0", so, 1);
    chk("cs_cnt0", shift_cnt, 0);
    chk("cs_done0", shift_done, 0);
    for (int n = 1; n <= 12; n++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("cs_so", so, (n < L) ? cw16[n] : 1'b0);
      chk("cs_cnt", shift_cnt, (n < L) ? n : L);
      chk("cs_done", shift_done, (n >= L) ? 1 : 0);
    end

    // Hold
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 5; h++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold_so", so, 1);
      chk("hold_cnt", shift_cnt, 2);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold_resume_so", so, 0);

    // Update / EXTEST
    shift_word(16'h013C);
    chk("pre_upd_q", q_o, 8'hFF);
    chk("pre_upd_cnt", shift_cnt, L);
    chk("pre_upd_done", shift_done, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("upd_q", q_o, 8'h3C);
    func_i = 8'h81; mode = 1'b0;
    #1;
    chk("func_q", q_o, 8'h81);
    mode = 1'b1;
    #1;
    chk("extest_q", q_o, 8'h3C);

    // scan_en wins over capture and update
    d_i = 8'hFF;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sim1_q", q_o, 8'h3C);
    chk("sim1_so", so, 0);
    chk("sim1_cnt", shift_cnt, L);

    // Capture + update together: update takes pre-capture chain
    d_i = 8'h5A;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sim2_q", q_o, 8'h9E);
    chk("sim2_so", so, 0);
    chk("sim2_cnt", shift_cnt, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sim2_cap_q", q_o, 8'h5A);

`ifdef ITRX_AIB_PHY_BSR_PARITY_EN
    d_i = 8'h07;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_cell", so, 1);
    chk("par_done8", shift_done, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_done9", shift_done, 1);
    shift_word(16'h0007);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_err_bad", par_err, 1);
    chk("par_q", q_o, 8'h07);
    shift_word(16'h0107);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_err_good", par_err, 0);
`else
    chk("par_tied", par_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
